roadmap_path_search: RTL and testbench

Parametrised shortest-path search over a masked roadmap edge list held in external RAM. A breadth-first forward sweep labels each edge by the level at which it first reached a new pose. A backward walk from `endPose` then extracts one shortest chain of edges, one edge index per level. It sits between the collision-check stage, which supplies `edgeMask`, and the trajectory stage, which consumes `selectEdge`/`pathLen`. Against the previous generation it adds parametric sizes, a start/done/fail handshake, abort, early fail on an exhausted frontier, and a guaranteed-shortest result with deterministic tie-break.

---
 rtl/roadmap_pkg.sv | 27 ++
 rtl/edge_sweeper.sv | 111 +++++++++++
 rtl/roadmap_path_search.sv | 216 +++++++++++++++++++++
 tb/tb_roadmap_path_search.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/roadmap_pkg.sv
// Shared types and helpers for the roadmap shortest-path search.
package roadmap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FWD   = 3'd1,
        ST_FEVAL = 3'd2,
        ST_BWD   = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAIL  = 3'd5
    } state_t;

    localparam int   RAM_LAT  = 1;
    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_BWD = 1'b1;

    // Bit 'pos' of the one-hot vector selecting pose 'idx'.
    function automatic logic onehot_pose(input int unsigned idx, input int unsigned pos);
        return idx == pos;
    endfunction

    // LSB position of result slot k in the packed selectEdge bus.
    function automatic int unsigned edge_slot(input int unsigned k, input int unsigned edge_w);
        return k * edge_w;
    endfunction

endpackage

// File: rtl/edge_sweeper.sv
// Walks edge RAM addresses 0..EDGE_N-1, realigns returned words with their
// address and evaluates the forward-qualify or backward-hit condition.
module edge_sweeper
    import roadmap_pkg::*;
#(
    parameter int NODE_N = 66,
    parameter int EDGE_N = 1034,
    parameter int NODE_W = 8,
    parameter int EDGE_W = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                launch,
    input  logic                stop,
    input  logic                mode,
    input  logic                edge_en,
    input  logic [NODE_N-1:0]   snap,
    input  logic [NODE_W-1:0]   cur,
    input  logic [2*NODE_W-1:0] ram_data,
    output logic [EDGE_W-1:0]   ram_address,
    output logic                data_valid,
    output logic                data_last,
    output logic [EDGE_W-1:0]   data_addr,
    output logic                match,
    output logic [NODE_N-1:0]   p_set,
    output logic [NODE_N-1:0]   q_set,
    output logic [NODE_W-1:0]   other_pose
);

    localparam logic [EDGE_W-1:0] LAST_ADDR = EDGE_W'(EDGE_N - 1);

    logic                issuing_q, issuing_d;
    logic [EDGE_W-1:0]   addr_q, addr_d;
    logic [RAM_LAT-1:0]  vld_q, vld_d;
    logic [EDGE_W-1:0]   tag_q [RAM_LAT];
    logic [EDGE_W-1:0]   tag_d [RAM_LAT];

    always_comb begin
        issuing_d = issuing_q;
        addr_d    = addr_q;
        vld_d     = '0;
        tag_d     = tag_q;
        vld_d[0]  = issuing_q;
        tag_d[0]  = addr_q;
        for (int i = 1; i < RAM_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
        // The counter parks on the last address so ramAddress holds when idle.
        if (issuing_q) begin
            if (addr_q == LAST_ADDR) begin
                issuing_d = 1'b0;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
        if (stop) begin
            issuing_d = 1'b0;
            vld_d     = '0;
        end
        if (launch) begin
            issuing_d = 1'b1;
            addr_d    = '0;
            vld_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issuing_q <= 1'b0;
            addr_q    <= '0;
            vld_q     <= '0;
            for (int i = 0; i < RAM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            issuing_q <= issuing_d;
            addr_q    <= addr_d;
            vld_q     <= vld_d;
            tag_q     <= tag_d;
        end
    end

    assign ram_address = addr_q;
    assign data_valid  = vld_q[RAM_LAT-1];
    assign data_addr   = tag_q[RAM_LAT-1];
    assign data_last   = data_valid && (data_addr == LAST_ADDR);

    logic [NODE_W-1:0] p_pose, q_pose;
    logic              p_in, q_in, qualify, hit;

    assign p_pose = ram_data[2*NODE_W-1:NODE_W];
    assign q_pose = ram_data[NODE_W-1:0];

    // Out-of-range poses decode to an all-zero vector and so belong to no set.
    genvar gi;
    generate
        for (gi = 0; gi < NODE_N; gi++) begin : g_pose_oh
            assign p_set[gi] = onehot_pose(32'(p_pose), unsigned'(gi));
            assign q_set[gi] = onehot_pose(32'(q_pose), unsigned'(gi));
        end
    endgenerate

    assign p_in       = |(p_set & snap);
    assign q_in       = |(q_set & snap);
    assign qualify    = edge_en && (p_in ^ q_in);
    assign hit        = edge_en && ((p_pose == cur) || (q_pose == cur));
    assign match      = data_valid && ((mode == MODE_BWD) ? hit : qualify);
    assign other_pose = (p_pose == cur) ? q_pose : p_pose;

endmodule

// File: rtl/roadmap_path_search.sv
// Breadth-first forward labelling of roadmap edges followed by a backward
// walk from the goal that extracts one lowest-index shortest edge chain.
module roadmap_path_search
    import roadmap_pkg::*;
#(
    parameter int NODE_N    = 66,
    parameter int EDGE_N    = 1034,
    parameter int NODE_W    = 8,
    parameter int EDGE_W    = 11,
    parameter int MAX_LEVEL = 10,
    parameter int LVL_W     = 4
) (
    input  logic                        CLK,
    input  logic                        RST_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NODE_W-1:0]           startPose,
    input  logic [NODE_W-1:0]           endPose,
    input  logic [EDGE_N-1:0]           edgeMask,
    output logic [EDGE_W-1:0]           ramAddress,
    input  logic [2*NODE_W-1:0]         RAMData,
    output logic                        busy,
    output logic                        done,
    output logic                        fail,
    output logic [LVL_W-1:0]            pathLen,
    output logic [MAX_LEVEL*EDGE_W-1:0] selectEdge,
    output logic [2:0]                  state
);

    state_t                        state_q, state_d;
    logic [NODE_N-1:0]             visited_q, visited_d;
    logic [NODE_N-1:0]             snap_q, snap_d;
    logic [EDGE_N-1:0]             mask_q, mask_d;
    logic [NODE_W-1:0]             end_q, end_d;
    logic [NODE_W-1:0]             cur_q, cur_d;
    logic [LVL_W-1:0]              level_q, level_d;
    logic [LVL_W-1:0]              k_q, k_d;
    logic [LVL_W-1:0]              path_len_q, path_len_d;
    logic [MAX_LEVEL*EDGE_W-1:0]   select_q, select_d;
    logic [EDGE_N-1:0]             level_edge_q [MAX_LEVEL];
    logic [EDGE_N-1:0]             level_edge_d [MAX_LEVEL];

    logic                launch, stop, mode, edge_en;
    logic                data_valid, data_last, match;
    logic [EDGE_W-1:0]   data_addr;
    logic [NODE_N-1:0]   p_set, q_set, start_oh, end_oh;
    logic [NODE_W-1:0]   other_pose;

    genvar gi;
    generate
        for (gi = 0; gi < NODE_N; gi++) begin : g_oh
            assign start_oh[gi] = onehot_pose(32'(startPose), unsigned'(gi));
            assign end_oh[gi]   = onehot_pose(32'(end_q), unsigned'(gi));
        end
    endgenerate

    assign mode    = (state_q == ST_BWD) ? MODE_BWD : MODE_FWD;
    assign edge_en = (mode == MODE_BWD) ? level_edge_q[k_q][data_addr] : !mask_q[data_addr];

    edge_sweeper #(
        .NODE_N (NODE_N),
        .EDGE_N (EDGE_N),
        .NODE_W (NODE_W),
        .EDGE_W (EDGE_W)
    ) u_sweeper (
        .clk         (CLK),
        .rst_n       (RST_n),
        .launch      (launch),
        .stop        (stop),
        .mode        (mode),
        .edge_en     (edge_en),
        .snap        (snap_q),
        .cur         (cur_q),
        .ram_data    (RAMData),
        .ram_address (ramAddress),
        .data_valid  (data_valid),
        .data_last   (data_last),
        .data_addr   (data_addr),
        .match       (match),
        .p_set       (p_set),
        .q_set       (q_set),
        .other_pose  (other_pose)
    );

    always_comb begin
        state_d      = state_q;
        visited_d    = visited_q;
        snap_d       = snap_q;
        mask_d       = mask_q;
        end_d        = end_q;
        cur_d        = cur_q;
        level_d      = level_q;
        k_d          = k_q;
        path_len_d   = path_len_q;
        select_d     = select_q;
        level_edge_d = level_edge_q;
        launch       = 1'b0;
        stop         = 1'b0;

        if (abort) begin
            state_d    = ST_IDLE;
            path_len_d = '0;
            select_d   = '0;
            stop       = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        for (int i = 0; i < MAX_LEVEL; i++) begin
                            level_edge_d[i] = '0;
                        end
                        select_d   = '0;
                        visited_d  = start_oh;
                        snap_d     = start_oh;
                        level_d    = '0;
                        path_len_d = '0;
                        mask_d     = edgeMask;
                        end_d      = endPose;
                        if (startPose == endPose) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_FWD;
                            launch  = 1'b1;
                        end
                    end
                end
                ST_FWD: begin
                    if (match) begin
                        level_edge_d[level_q][data_addr] = 1'b1;
                        visited_d = visited_q | p_set | q_set;
                    end
                    if (data_last) begin
                        state_d = ST_FEVAL;
                    end
                end
                ST_FEVAL: begin
                    if (|(visited_q & end_oh)) begin
                        path_len_d = level_q + 1'b1;
                        cur_d      = end_q;
                        k_d        = level_q;
                        state_d    = ST_BWD;
                        launch     = 1'b1;
                    end else if (visited_q == snap_q) begin
                        state_d = ST_FAIL;
                    end else if (level_q + 1'b1 == LVL_W'(MAX_LEVEL)) begin
                        state_d = ST_FAIL;
                    end else begin
                        level_d = level_q + 1'b1;
                        snap_d  = visited_q;
                        state_d = ST_FWD;
                        launch  = 1'b1;
                    end
                end
                ST_BWD: begin
                    // First hit wins; relaunching or stopping drops the in-flight word.
                    if (match) begin
                        for (int s = 0; s < MAX_LEVEL; s++) begin
                            if (k_q == LVL_W'(s)) begin
                                select_d[edge_slot(unsigned'(s), unsigned'(EDGE_W)) +: EDGE_W] = data_addr;
                            end
                        end
                        cur_d = other_pose;
                        if (k_q == '0) begin
                            state_d = ST_DONE;
                            stop    = 1'b1;
                        end else begin
                            k_d    = k_q - 1'b1;
                            launch = 1'b1;
                        end
                    end else if (data_last) begin
                        state_d = ST_FAIL;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= ST_IDLE;
            visited_q  <= '0;
            snap_q     <= '0;
            mask_q     <= '0;
            end_q      <= '0;
            cur_q      <= '0;
            level_q    <= '0;
            k_q        <= '0;
            path_len_q <= '0;
            select_q   <= '0;
            for (int i = 0; i < MAX_LEVEL; i++) begin
                level_edge_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            visited_q    <= visited_d;
            snap_q       <= snap_d;
            mask_q       <= mask_d;
            end_q        <= end_d;
            cur_q        <= cur_d;
            level_q      <= level_d;
            k_q          <= k_d;
            path_len_q   <= path_len_d;
            select_q     <= select_d;
            level_edge_q <= level_edge_d;
        end
    end

    assign busy       = (state_q == ST_FWD) || (state_q == ST_FEVAL) || (state_q == ST_BWD);
    assign done       = (state_q == ST_DONE);
    assign fail       = (state_q == ST_FAIL);
    assign pathLen    = path_len_q;
    assign selectEdge = select_q;
    assign state      = state_q;

endmodule

// File: tb/tb_roadmap_path_search.sv
// Directed bench for roadmap_path_search on an 8-pose, 8-edge roadmap.
module tb_roadmap_path_search;

    localparam int NODE_N = 8, EDGE_N = 8, NODE_W = 3, EDGE_W = 3, MAX_LEVEL = 4, LVL_W = 3;

    logic                        CLK = 1'b0;
    logic                        RST_n;
    logic                        start, abort;
    logic [NODE_W-1:0]           startPose, endPose;
    logic [EDGE_N-1:0]           edgeMask;
    logic [EDGE_W-1:0]           ramAddress;
    logic [2*NODE_W-1:0]         RAMData;
    logic                        busy, done, fail;
    logic [LVL_W-1:0]            pathLen;
    logic [MAX_LEVEL*EDGE_W-1:0] selectEdge;
    logic [2:0]                  state;

    logic [2*NODE_W-1:0] ram [EDGE_N];
    int total = 0;
    int bad   = 0;
    int cyc;
    logic [EDGE_W-1:0] addr_before;

    always #5 CLK = ~CLK;
    always @(posedge CLK) RAMData <= ram[ramAddress];

    roadmap_path_search #(
        .NODE_N(NODE_N), .EDGE_N(EDGE_N), .NODE_W(NODE_W), .EDGE_W(EDGE_W),
        .MAX_LEVEL(MAX_LEVEL), .LVL_W(LVL_W)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .abort(abort),
        .startPose(startPose), .endPose(endPose), .edgeMask(edgeMask),
        .ramAddress(ramAddress), .RAMData(RAMData),
        .busy(busy), .done(done), .fail(fail),
        .pathLen(pathLen), .selectEdge(selectEdge), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_base();
        ram[0] = {3'd0, 3'd1}; ram[1] = {3'd1, 3'd2}; ram[2] = {3'd2, 3'd3}; ram[3] = {3'd0, 3'd4};
        ram[4] = {3'd4, 3'd3}; ram[5] = {3'd5, 3'd6}; ram[6] = {3'd2, 3'd2}; ram[7] = {3'd3, 3'd0};
    endtask

    // Pulse start, scramble the latched inputs, count cycles until done/fail.
    task automatic run(input logic [2:0] s, input logic [2:0] e, input logic [7:0] m, output int n);
        startPose = s; endPose = e; edgeMask = m; start = 1'b1;
        tick();
        start = 1'b0; startPose = 3'd7; endPose = 3'd6; edgeMask = 8'hFF;
        n = 0;
        while (!(done || fail) && n < 200) begin
            n++;
            tick();
        end
        $display("run %0d->%0d mask=%02h: cycles=%0d done=%0b fail=%0b pathLen=%0d select=%03h",
                 s, e, m, n, done, fail, pathLen, selectEdge);
        check("finished", 32'(done | fail), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        load_base();
        RST_n = 1'b0; start = 1'b0; abort = 1'b0;
        startPose = '0; endPose = '0; edgeMask = '0;
        tick(); tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_addr", 32'(ramAddress), 32'd0);
        check("rst_flags", 32'({busy, done, fail}), 32'd0);
        check("rst_len_sel", 32'({pathLen, selectEdge}), 32'd0);
        RST_n = 1'b1;
        tick();

        // Edge 7 blocked: two hops through pose 4.
        run(3'd0, 3'd3, 8'h80, cyc);
        check("m80_done", 32'(done), 32'd1);
        check("m80_len", 32'(pathLen), 32'd2);
        check("m80_sel", 32'(selectEdge), 32'h023);
        check("m80_cyc", 32'(cyc), 32'd31);

        run(3'd0, 3'd3, 8'h90, cyc);
        check("m90_len", 32'(pathLen), 32'd3);
        check("m90_sel", 32'(selectEdge), 32'h088);
        check("m90_cyc", 32'(cyc), 32'd39);

        run(3'd0, 3'd3, 8'h00, cyc);
        check("m00_state", 32'(state), 32'd4);
        check("m00_len", 32'(pathLen), 32'd1);
        check("m00_sel", 32'(selectEdge), 32'h007);
        check("m00_cyc", 32'(cyc), 32'd19);

        // Edges 1,2 blocked: level 0 reaches {0,1,3,4}, level 1 adds nothing.
        run(3'd0, 3'd5, 8'h06, cyc);
        check("unreach_fail", 32'(fail), 32'd1);
        check("unreach_state", 32'(state), 32'd5);
        check("unreach_cyc", 32'(cyc), 32'd20);
        check("unreach_sel", 32'(selectEdge), 32'd0);
        check("unreach_len", 32'(pathLen), 32'd0);

        addr_before = ramAddress;
        startPose = 3'd2; endPose = 3'd2; edgeMask = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        $display("same pose 2->2: done=%0b pathLen=%0d addr=%0d", done, pathLen, ramAddress);
        check("same_done", 32'(done), 32'd1);
        check("same_len", 32'(pathLen), 32'd0);
        check("same_addr", 32'(ramAddress), 32'(addr_before));

        // Abort partway through the backward walk.
        startPose = 3'd0; endPose = 3'd3; edgeMask = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (state != 3'd3 && cyc < 40) begin
            cyc++;
            tick();
        end
        check("reach_bwd", 32'(state), 32'd3);
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        $display("abort in BWD: state=%0d pathLen=%0d select=%03h", state, pathLen, selectEdge);
        check("abort_state", 32'(state), 32'd0);
        check("abort_flags", 32'({busy, done, fail}), 32'd0);
        check("abort_len_sel", 32'({pathLen, selectEdge}), 32'd0);

        startPose = 3'd1; endPose = 3'd1; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        $display("abort with start: state=%0d done=%0b", state, done);
        check("abort_prio", 32'({state, done}), 32'd0);

        // Asynchronous reset in the middle of a forward sweep.
        startPose = 3'd0; endPose = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        RST_n = 1'b0;
        #1;
        $display("reset in FWD: state=%0d addr=%0d busy=%0b", state, ramAddress, busy);
        check("arst_state", 32'(state), 32'd0);
        check("arst_addr", 32'(ramAddress), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        tick();
        RST_n = 1'b1;
        tick();

        // Linear chain 0-1-2-3-4-5, remaining edges blocked.
        ram[3] = {3'd3, 3'd4}; ram[4] = {3'd4, 3'd5};
        run(3'd0, 3'd5, 8'hE0, cyc);
        check("chain_fail", 32'(fail), 32'd1);
        check("chain_fail_cyc", 32'(cyc), 32'd40);

        run(3'd0, 3'd4, 8'hE0, cyc);
        check("chain4_done", 32'(done), 32'd1);
        check("chain4_len", 32'(pathLen), 32'd4);
        check("chain4_sel", 32'(selectEdge), 32'h688);
        check("chain4_cyc", 32'(cyc), 32'd54);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
